// File: rtl/pll_dyn_ctrl_pkg.sv
// Shared types, mode table and divider-code encoders for the PLL retune controller.
package pll_dyn_pkg;

  typedef logic [5:0] dsel_t;
  typedef logic [1:0] mode_idx_t;

  typedef struct packed {
    logic [5:0] idiv;
    logic [5:0] fbdiv;
    logic [7:0] odiv;
  } mode_t;

  localparam mode_t MODE_TABLE [0:3] = '{
    '{idiv: 6'd0, fbdiv: 6'd19, odiv: 8'd2},  // 540 MHz
    '{idiv: 6'd2, fbdiv: 6'd13, odiv: 8'd4},  // 126 MHz
    '{idiv: 6'd3, fbdiv: 6'd54, odiv: 8'd2},  // 371.25 MHz
    '{idiv: 6'd0, fbdiv: 6'd4,  odiv: 8'd4}   // 135 MHz
  };

  localparam int LOSS_CYC = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_WAIT_LOCK,
    ST_ERROR
  } state_t;

  function automatic dsel_t enc_fbd(input logic [5:0] fbdiv);
    return 6'd63 - fbdiv;
  endfunction

  function automatic dsel_t enc_id(input logic [5:0] idiv);
    return 6'd63 - idiv;
  endfunction

  function automatic dsel_t enc_od(input logic [7:0] odiv);
    case (odiv)
      8'd2:    return 6'd63;
      8'd4:    return 6'd62;
      8'd8:    return 6'd60;
      8'd16:   return 6'd56;
      8'd32:   return 6'd48;
      8'd48:   return 6'd40;
      8'd64:   return 6'd32;
      8'd80:   return 6'd24;
      8'd96:   return 6'd16;
      8'd112:  return 6'd8;
      8'd128:  return 6'd0;
      default: return 6'd63;
    endcase
  endfunction

endpackage

// File: rtl/pll_dyn_ctrl_if.sv
// Request/PLL/video-side signal bundle of the PLL retune controller.
interface pll_dyn_ctrl_if;
  import pll_dyn_pkg::*;

  mode_idx_t mode_req;
  logic      req_valid;
  logic      req_ready;
  logic      pll_lock;
  dsel_t     fbdsel;
  dsel_t     idsel;
  dsel_t     odsel;
  mode_idx_t cur_mode;
  logic      video_rstn;
  logic      busy;
  logic      err;

  modport master (
    output mode_req, req_valid, pll_lock,
    input  req_ready, fbdsel, idsel, odsel, cur_mode, video_rstn, busy, err
  );

  modport slave (
    input  mode_req, req_valid, pll_lock,
    output req_ready, fbdsel, idsel, odsel, cur_mode, video_rstn, busy, err
  );
endinterface

// File: rtl/pll_dyn_ctrl_lock_filter.sv
// Synchronises the PLL LOCK and qualifies it: a stable-high run while waiting,
// and a sustained-low run while locked.
module pll_lock_filter
  import pll_dyn_pkg::*;
#(
  parameter int STABLE_CYC = 1024
) (
  input  logic clk,
  input  logic resetn,
  input  logic lock_async_i,
  input  logic stable_en_i,
  input  logic loss_en_i,
  output logic lock_sync_o,
  output logic lock_stable_o,
  output logic lock_lost_o
);
  localparam int SW = $clog2(STABLE_CYC) + 1;
  localparam int LW = $clog2(LOSS_CYC) + 1;

  logic [1:0]    sync_q;
  logic [SW-1:0] stab_q, stab_d;
  logic [LW-1:0] loss_q, loss_d;

  assign lock_sync_o   = sync_q[1];
  assign lock_stable_o = stable_en_i && lock_sync_o && (stab_q == SW'(STABLE_CYC - 1));
  assign lock_lost_o   = loss_en_i && !lock_sync_o && (loss_q == LW'(LOSS_CYC - 1));

  // Counters only run while their owning state enables them, so each
  // state entry starts from zero.
  always_comb begin
    stab_d = '0;
    loss_d = '0;
    if (stable_en_i && lock_sync_o)
      stab_d = (stab_q == SW'(STABLE_CYC)) ? stab_q : stab_q + 1'b1;
    if (loss_en_i && !lock_sync_o)
      loss_d = (loss_q == LW'(LOSS_CYC)) ? loss_q : loss_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
      stab_q <= '0;
      loss_q <= '0;
    end else begin
      sync_q <= {sync_q[0], lock_async_i};
      stab_q <= stab_d;
      loss_q <= loss_d;
    end
  end
endmodule

// File: rtl/pll_dyn_ctrl.sv
// Retunes the PLLVR dynamic dividers between video modes and holds the video
// domain in reset until the new frequency has locked stably.
module pll_dyn_ctrl
  import pll_dyn_pkg::*;
#(
  parameter int SETTLE_CYC  = 64,
  parameter int STABLE_CYC  = 1024,
  parameter int TIMEOUT_CYC = 2700000,
  parameter int MAX_RETRY   = 3
) (
  input logic          clk,
  input logic          resetn,
  pll_dyn_ctrl_if.slave bus
);
  localparam int CNT_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam int RW      = $clog2(MAX_RETRY) + 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  mode_idx_t     tgt_q, tgt_d;
  mode_idx_t     mode_q, mode_d;
  dsel_t         fbd_q, fbd_d, id_q, id_d, od_q, od_d;
  logic          err_q, err_d;
  logic          accept, lock_sync, lock_stable, lock_lost;

  pll_lock_filter #(.STABLE_CYC(STABLE_CYC)) u_filt (
    .clk          (clk),
    .resetn       (resetn),
    .lock_async_i (bus.pll_lock),
    .stable_en_i  (state_q == ST_WAIT_LOCK),
    .loss_en_i    (state_q == ST_IDLE),
    .lock_sync_o  (lock_sync),
    .lock_stable_o(lock_stable),
    .lock_lost_o  (lock_lost)
  );

  assign bus.req_ready  = (state_q == ST_IDLE) || (state_q == ST_ERROR);
  assign bus.busy       = (state_q == ST_APPLY) || (state_q == ST_SETTLE) ||
                          (state_q == ST_WAIT_LOCK);
  assign bus.video_rstn = (state_q == ST_IDLE);
  assign bus.err        = err_q;
  assign bus.fbdsel     = fbd_q;
  assign bus.idsel      = id_q;
  assign bus.odsel      = od_q;
  assign bus.cur_mode   = mode_q;
  assign accept         = bus.req_valid && bus.req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == CW'(CNT_MAX)) ? cnt_q : cnt_q + 1'b1;
    retry_d = retry_q;
    tgt_d   = tgt_q;
    err_d   = err_q;
    mode_d  = mode_q;
    fbd_d   = fbd_q;
    id_d    = id_q;
    od_d    = od_q;

    if (accept) begin
      tgt_d   = bus.mode_req;
      err_d   = 1'b0;
      retry_d = '0;
      state_d = ST_APPLY;
    end else begin
      unique case (state_q)
        ST_IDLE:
          if (lock_lost && !lock_sync) state_d = ST_SETTLE;
        ST_APPLY: begin
          // Retries land here too, so the same codes are simply re-driven.
          mode_d  = tgt_q;
          fbd_d   = enc_fbd(MODE_TABLE[tgt_q].fbdiv);
          id_d    = enc_id(MODE_TABLE[tgt_q].idiv);
          od_d    = enc_od(MODE_TABLE[tgt_q].odiv);
          state_d = ST_SETTLE;
        end
        ST_SETTLE:
          if (cnt_q == CW'(SETTLE_CYC - 1)) state_d = ST_WAIT_LOCK;
        ST_WAIT_LOCK:
          if (lock_stable) begin
            retry_d = '0;
            state_d = ST_IDLE;
          end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
            if (retry_q < RW'(MAX_RETRY)) begin
              retry_d = retry_q + 1'b1;
              state_d = ST_APPLY;
            end else begin
              err_d   = 1'b1;
              state_d = ST_ERROR;
            end
          end
        ST_ERROR: ;
        default: state_d = ST_SETTLE;
      endcase
    end

    if (state_d != state_q) cnt_d = '0;
  end

  // Power-up behaves like a reconfiguration to mode 0 already in SETTLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_SETTLE;
      cnt_q   <= '0;
      retry_q <= '0;
      tgt_q   <= '0;
      err_q   <= 1'b0;
      mode_q  <= '0;
      fbd_q   <= enc_fbd(MODE_TABLE[0].fbdiv);
      id_q    <= enc_id(MODE_TABLE[0].idiv);
      od_q    <= enc_od(MODE_TABLE[0].odiv);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      tgt_q   <= tgt_d;
      err_q   <= err_d;
      mode_q  <= mode_d;
      fbd_q   <= fbd_d;
      id_q    <= id_d;
      od_q    <= od_d;
    end
  end
endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Self-checking bench for pll_dyn_ctrl: cycle model of the retune sequence plus
// directed scenarios and randomized request/LOCK traffic.
module tb_pll_dyn_ctrl;
  localparam int SETTLE = 16;
  localparam int STABLE = 64;
  localparam int TMO    = 1000;
  localparam int MAXR   = 3;

  localparam int P_IDLE = 0, P_APPLY = 1, P_SETTLE = 2, P_WAIT = 3, P_ERR = 4;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  pll_dyn_ctrl_if bus();

  pll_dyn_ctrl #(
    .SETTLE_CYC (SETTLE),
    .STABLE_CYC (STABLE),
    .TIMEOUT_CYC(TMO),
    .MAX_RETRY  (MAXR)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  int n_vec = 0, n_miss = 0, n_print = 0;

  // Mode table as {IDIV, FBDIV, ODIV}
  int t_idiv [4] = '{0, 2, 3, 0};
  int t_fbdiv[4] = '{19, 13, 54, 4};
  int t_odiv [4] = '{2, 4, 2, 4};

  int m_ph, m_cnt, m_stab, m_loss, m_retry, m_tgt, m_mode, m_err, m_s1, m_s2;

  task automatic mdl_reset();
    m_ph = P_SETTLE; m_cnt = 0; m_stab = 0; m_loss = 0; m_retry = 0;
    m_tgt = 0; m_mode = 0; m_err = 0; m_s1 = 0; m_s2 = 0;
  endtask

  task automatic mdl_step();
    int sy, nph, lk;
    sy  = m_s2;
    nph = m_ph;
    lk  = int'(bus.pll_lock);
    if (bus.req_valid && (m_ph == P_IDLE || m_ph == P_ERR)) begin
      m_tgt = int'(bus.mode_req); m_err = 0; m_retry = 0; nph = P_APPLY;
    end else begin
      case (m_ph)
        P_IDLE: begin
          m_loss = sy ? 0 : m_loss + 1;
          if (m_loss == 8) nph = P_SETTLE;
        end
        P_APPLY: begin m_mode = m_tgt; nph = P_SETTLE; end
        P_SETTLE: begin
          m_cnt++;
          if (m_cnt == SETTLE) nph = P_WAIT;
        end
        P_WAIT: begin
          m_cnt++;
          m_stab = sy ? m_stab + 1 : 0;
          if (m_stab == STABLE) begin
            nph = P_IDLE; m_retry = 0;
          end else if (m_cnt == TMO) begin
            if (m_retry < MAXR) begin m_retry++; nph = P_APPLY; end
            else begin nph = P_ERR; m_err = 1; end
          end
        end
        default: ;
      endcase
    end
    if (nph != m_ph) begin m_cnt = 0; m_stab = 0; m_loss = 0; end
    m_ph = nph;
    m_s2 = m_s1;
    m_s1 = lk;
  endtask

  initial begin
    mdl_reset();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) mdl_reset();
      else mdl_step();
    end
  end

  // Cycle-by-cycle compare against the model
  initial begin
    forever begin
      int e_fbd, e_id, e_od, e_vr, e_busy, e_rdy;
      @(negedge clk);
      e_fbd  = 63 - t_fbdiv[m_mode];
      e_id   = 63 - t_idiv[m_mode];
      e_od   = 64 - t_odiv[m_mode] / 2;
      e_vr   = (m_ph == P_IDLE);
      e_busy = (m_ph == P_APPLY || m_ph == P_SETTLE || m_ph == P_WAIT);
      e_rdy  = (m_ph == P_IDLE || m_ph == P_ERR);
      n_vec++;
      if (int'(bus.fbdsel) != e_fbd || int'(bus.idsel) != e_id || int'(bus.odsel) != e_od ||
          int'(bus.cur_mode) != m_mode || int'(bus.video_rstn) != e_vr ||
          int'(bus.busy) != e_busy || int'(bus.req_ready) != e_rdy || int'(bus.err) != m_err) begin
        n_miss++;
        if (n_print < 20) begin
          n_print++;
          $display("FAIL model_cmp t=%0t got fbd=%0d id=%0d od=%0d mode=%0d vrst=%0d busy=%0d rdy=%0d err=%0d want fbd=%0d id=%0d od=%0d mode=%0d vrst=%0d busy=%0d rdy=%0d err=%0d",
                   $time, bus.fbdsel, bus.idsel, bus.odsel, bus.cur_mode, bus.video_rstn,
                   bus.busy, bus.req_ready, bus.err, e_fbd, e_id, e_od, m_mode, e_vr,
                   e_busy, e_rdy, m_err);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_vid(input int bound, output int cyc);
    cyc = 0;
    while (bus.video_rstn !== 1'b1 && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Issue a request when ready; returns at the negedge just after the accept edge
  task automatic req(input int m, input string nm);
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_ready"}, int'(bus.req_ready), 1);
    bus.mode_req  = 2'(m);
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic chk_codes(input string nm, input int fbd, input int id, input int od, input int md);
    chk({nm, "_fbd"}, int'(bus.fbdsel), fbd);
    chk({nm, "_id"},  int'(bus.idsel),  id);
    chk({nm, "_od"},  int'(bus.odsel),  od);
    chk({nm, "_mode"}, int'(bus.cur_mode), md);
  endtask

  initial begin
    int cyc, run;
    bus.mode_req  = '0;
    bus.req_valid = 1'b0;
    bus.pll_lock  = 1'b0;
    #1 resetn = 1'b0;
    tick(3);
    chk_codes("rst", 44, 63, 63, 0);
    chk("rst_vrst", int'(bus.video_rstn), 0);
    chk("rst_busy", int'(bus.busy), 1);
    chk("rst_rdy",  int'(bus.req_ready), 0);
    chk("rst_err",  int'(bus.err), 0);
    resetn = 1'b1;

    // Power-up: PLL locks 200 cycles after reset release
    tick(200);
    bus.pll_lock = 1'b1;
    wait_vid(400, cyc);
    chk("pwr_lock_latency", cyc, 2 + STABLE);
    chk("pwr_busy", int'(bus.busy), 0);
    chk_codes("pwr", 44, 63, 63, 0);

    // Retune to mode 2 with a one-cycle LOCK glitch late in the stable run
    bus.pll_lock = 1'b0;
    req(2, "m2");
    chk("m2_vrst", int'(bus.video_rstn), 0);
    @(negedge clk);
    chk_codes("m2", 9, 60, 63, 2);
    tick(SETTLE + 4);
    bus.pll_lock = 1'b1;
    tick(STABLE - 10);
    chk("m2_pre_glitch_vrst", int'(bus.video_rstn), 0);
    bus.pll_lock = 1'b0;
    tick(1);
    bus.pll_lock = 1'b1;
    wait_vid(400, cyc);
    chk("m2_glitch_latency", cyc, 2 + STABLE);

    // Mode 1, then lock-loss boundary: 7 low cycles tolerated, 8 are not
    bus.pll_lock = 1'b0;
    req(1, "m1");
    @(negedge clk);
    chk_codes("m1", 50, 61, 62, 1);
    tick(SETTLE + 2);
    bus.pll_lock = 1'b1;
    wait_vid(400, cyc);
    chk("m1_lock_latency", cyc, 2 + STABLE);
    bus.pll_lock = 1'b0;
    tick(7);
    bus.pll_lock = 1'b1;
    tick(4);
    chk("loss7_vrst", int'(bus.video_rstn), 1);
    bus.pll_lock = 1'b0;
    tick(8);
    bus.pll_lock = 1'b1;
    tick(3);
    chk("loss8_vrst", int'(bus.video_rstn), 0);
    chk("loss8_busy", int'(bus.busy), 1);
    chk_codes("loss8", 50, 61, 62, 1);
    wait_vid(400, cyc);
    chk("loss8_relock_vrst", int'(bus.video_rstn), 1);

    // LOCK never comes: first attempt plus MAX_RETRY retries, then ERROR
    bus.pll_lock = 1'b0;
    req(3, "tmo");
    cyc = 0;
    while (bus.req_ready !== 1'b1 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
    end
    chk("tmo_cycles", cyc, 4 * (1 + SETTLE + TMO));
    chk("tmo_err", int'(bus.err), 1);
    chk("tmo_vrst", int'(bus.video_rstn), 0);
    chk_codes("tmo", 59, 63, 62, 3);
    req(1, "err_clr");
    chk("err_clr_err", int'(bus.err), 0);
    chk("err_clr_busy", int'(bus.busy), 1);
    tick(SETTLE + 2);
    bus.pll_lock = 1'b1;
    wait_vid(400, cyc);
    chk("err_clr_relock", int'(bus.video_rstn), 1);

    // Async reset during SETTLE of mode 3; busy requests are dropped
    bus.pll_lock = 1'b0;
    req(3, "m3");
    @(negedge clk);
    tick(2);
    bus.mode_req  = 2'd1;
    bus.req_valid = 1'b1;
    tick(2);
    bus.req_valid = 1'b0;
    tick(1);
    chk("busy_req_ignored", int'(bus.cur_mode), 3);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk_codes("arst", 44, 63, 63, 0);
    chk("arst_vrst", int'(bus.video_rstn), 0);
    chk("arst_busy", int'(bus.busy), 1);
    chk("arst_rdy",  int'(bus.req_ready), 0);
    @(negedge clk);
    resetn = 1'b1;
    bus.pll_lock = 1'b1;
    wait_vid(400, cyc);
    chk("arst_relock", int'(bus.video_rstn), 1);

    // Random requests and LOCK run-lengths, checked by the model every cycle
    run = 0;
    for (int i = 0; i < 6000; i++) begin
      if (run == 0) begin
        bus.pll_lock = ~bus.pll_lock;
        run = bus.pll_lock ? int'($urandom_range(20, 300)) : int'($urandom_range(1, 12));
      end
      run--;
      bus.req_valid = ($urandom_range(0, 19) == 0);
      bus.mode_req  = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.pll_lock  = 1'b1;
    tick(400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
